// File: rtl/vedic_pkg.sv
// Shared types for the sequential Vedic multiplier. These are the FSM state
// encoding and the partial-product step counter.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_FIRST = 2'd0;
    localparam step_t STEP_LAST  = 2'd3;

endpackage : vedic_pkg

// File: rtl/vedic_mult.sv
// Half-width unsigned multiplier. It is purely combinational, and the
// sequential top time-shares it across the four cross products.
module vedic_mult #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;

    // Zero-extend first so the product is formed at full result width.
    always_comb begin
        a_ext_s = {{WIDTH{1'b0}}, a};
        b_ext_s = {{WIDTH{1'b0}}, b};
        p       = a_ext_s * b_ext_s;
    end

endmodule : vedic_mult

// File: rtl/vedic_mult_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier. It builds the product from four
// half-width cross products on one shared multiplier, with valid/ready at both ends.
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    state_t           state_r;
    step_t            step_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    out_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [HALF-1:0]  mul_a_s;
    logic [HALF-1:0]  mul_b_s;
    logic [WIDTH-1:0] pp_s;
    logic [PW-1:0]    pp_ext_s;
    logic [PW-1:0]    pp_shift_s;
    logic [PW-1:0]    acc_next_s;

    // Step bit 1 picks the upper half of a, and step bit 0 picks the upper half of b.
    always_comb begin
        mul_a_s = step_r[1] ? a_r[WIDTH-1:HALF] : a_r[HALF-1:0];
        mul_b_s = step_r[0] ? b_r[WIDTH-1:HALF] : b_r[HALF-1:0];
    end

    vedic_mult #(
        .WIDTH(HALF)
    ) u_mult (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (pp_s)
    );

    // Align the partial product to its weight. The full-width sum cannot overflow.
    always_comb begin
        pp_ext_s = {{WIDTH{1'b0}}, pp_s};
        case (step_r)
            2'd0:       pp_shift_s = pp_ext_s;
            2'd1, 2'd2: pp_shift_s = pp_ext_s << HALF;
            2'd3:       pp_shift_s = pp_ext_s << WIDTH;
            default:    pp_shift_s = pp_ext_s;
        endcase
        acc_next_s = acc_r + pp_shift_s;
    end

    // Control FSM. It also drives the datapath registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            step_r      <= STEP_FIRST;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            acc_r       <= {PW{1'b0}};
            out_r       <= {PW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        acc_r      <= {PW{1'b0}};
                        step_r     <= STEP_FIRST;
                        state_r    <= MUL;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                MUL: begin
                    acc_r  <= acc_next_s;
                    step_r <= step_r + 2'd1;
                    if (step_r == STEP_LAST) begin
                        state_r     <= DONE;
                        out_r       <= acc_next_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= MUL;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    step_r      <= STEP_FIRST;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign busy      = busy_r;

endmodule : vedic_mult_seq

// File: doc/vedic_mult_seq.md
VEDIC_MULT_SEQ -- requirements
Module: vedic_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are powers of two >= 8.
REQ-002 SHALL derive localparam HALF = WIDTH/2 as the width of the shared half-width multiplier.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 SHALL have ports a, b, input, WIDTH each, unsigned operands.
REQ-008 SHALL have port out_valid, output, 1, product available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-010 SHALL have port out, output, 2*WIDTH, unsigned product a*b.
REQ-011 SHALL have port busy, output, 1, high in MUL or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DONE, plus a 2-bit step counter used in MUL.
REQ-013 SHALL accept an operand pair on a rising edge where in_valid && in_ready, registering a and b and clearing the accumulator, then entering MUL with step=0.
REQ-014 SHALL assert in_ready only in IDLE, registered; in_valid in MUL or DONE is ignored, with no capture and no error.
REQ-015 SHALL feed the single half-width multiplier in MUL according to step: 0 = a_lo*b_lo, 1 = a_lo*b_hi, 2 = a_hi*b_lo, 3 = a_hi*b_hi.
REQ-016 SHALL add each partial product into a 2*WIDTH accumulator, left-shifted by 0, HALF, HALF and WIDTH bits for steps 0-3 respectively.
REQ-017 SHALL use the zero-extended 2*WIDTH sum width; this sum cannot overflow and no carry-out is produced.
REQ-018 SHALL advance step by 1 per cycle in MUL; after step 3 accumulates, SHALL enter DONE.
REQ-019 SHALL set out_valid after exactly 4 rising edges following the accept edge, with out = a*b; latency is 4 cycles.
REQ-020 SHALL hold out and out_valid stable in DONE until out_ready is high on a rising edge.
REQ-021 SHALL, on that out handshake edge, return to IDLE, deassert out_valid, and assert in_ready; a new accept is earliest one cycle later, giving a minimum of 6 cycles per operation.
REQ-022 SHALL leave out holding the last product after the handshake; it is valid only when out_valid is high.
REQ-023 SHALL, if out_ready is already high when DONE is entered, complete the handshake on the next edge.

Reset
REQ-024 SHALL, while rst_n is low, force state=IDLE, step=0, accumulator=0, operand registers=0, out=0, out_valid=0, in_ready=0 and busy=0, regardless of clk.
REQ-025 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-026 SHALL discard any in-flight operation when reset is asserted mid-MUL or in DONE; no product is emitted afterwards.

Structure
REQ-027 SHALL take the state enum (IDLE/MUL/DONE) and the step typedef from shared package vedic_pkg.
REQ-028 SHALL instantiate exactly one sub-module, vedic_mult #(.WIDTH(HALF)), time-shared across all four steps; no other multiplier logic is permitted.
REQ-029 SHALL register the operand-half select and the accumulator; the multiplier path is combinational within one cycle.

Verification (WIDTH=16)
REQ-030 SHALL cover: a=0x1234, b=0x5678 accepted at edge k -> out_valid high after edge k+4, out=0x06260060.
REQ-031 SHALL cover: a=0xFFFF, b=0xFFFF -> out=0xFFFE0001, which checks the maximum-value boundary.
REQ-032 SHALL cover: a=0x0000, b=0xBEEF -> out=0x00000000; then a=0x0001, b=0xBEEF -> out=0x0000BEEF.
REQ-033 SHALL cover: out_ready held low for 3 cycles in DONE -> out and out_valid stable throughout; in_valid pulsed meanwhile with a=0x0002 is ignored, in_ready stays 0.
REQ-034 SHALL cover: rst_n pulsed low during MUL step 2 -> all outputs are 0 immediately, in_ready=1 one edge after release, and no stale product appears.
REQ-035 SHALL cover: back-to-back random operands with out_ready=1 -> accepts spaced 6 cycles apart, and every out equals the reference model a*b.
